prt_dptx_ctl_bank: RTL and testbench

Parametrised multi-channel control register bank for the DP TX path, driven by the egress side of a message slave (`prt_dp_msg_slv_egr`). A message carries a bit mask, a channel-select vector and a data word, so one message can update any subset of bits in any subset of channels, including broadcast. Each bit position has one of three write behaviours: immediate level, self-clearing pulse, or frame-synchronised (staged in a shadow register and committed on `SYNC_IN`). The bank feeds per-lane and per-stream controls in the link and video datapath.

---
 rtl/prt_dptx_ctl_bank.sv | 158 +++++++++++++++
 tb/tb_prt_dptx_ctl_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_dptx_ctl_bank.sv
// Multi-channel DP TX control register bank, written by masked/selected messages.
// Bits are immediate level, self-clearing pulse, or staged in a shadow until SYNC_IN.
module prt_dptx_ctl_bank #(
  parameter int P_MSG_IDX   = 5,
  parameter int P_MSG_DAT   = 16,
  parameter int P_CH        = 4,
  parameter int P_CTL_WIDTH = 8,
  parameter logic [P_CTL_WIDTH-1:0] P_PLS_MSK  = '0,
  parameter logic [P_CTL_WIDTH-1:0] P_SYNC_MSK = '0,
  parameter logic [P_CTL_WIDTH-1:0] P_RST_VAL  = '0
) (
  input  logic                          RST_IN,
  input  logic                          CLK_IN,
  input  logic [P_MSG_IDX-1:0]          MSG_IDX_IN,
  input  logic                          MSG_FIRST_IN,
  input  logic                          MSG_LAST_IN,
  input  logic [P_MSG_DAT-1:0]          MSG_DAT_IN,
  input  logic                          MSG_VLD_IN,
  input  logic                          SYNC_IN,
  output logic [P_CH*P_CTL_WIDTH-1:0]   CTL_OUT,
  output logic [P_CH-1:0]               CTL_UPD_OUT,
  output logic                          ERR_OUT
);

  localparam int W = P_CTL_WIDTH;
  localparam logic [W-1:0] LP_LVL_IMM  = ~P_PLS_MSK & ~P_SYNC_MSK;
  localparam logic [W-1:0] LP_PLS_IMM  =  P_PLS_MSK & ~P_SYNC_MSK;
  localparam logic [W-1:0] LP_LVL_SYNC = ~P_PLS_MSK &  P_SYNC_MSK;
  localparam logic [W-1:0] LP_PLS_SYNC =  P_PLS_MSK &  P_SYNC_MSK;
  localparam logic [P_MSG_IDX-1:0] LP_IDX_MSK = P_MSG_IDX'(0);
  localparam logic [P_MSG_IDX-1:0] LP_IDX_SEL = P_MSG_IDX'(1);
  localparam logic [P_MSG_IDX-1:0] LP_IDX_DAT = P_MSG_IDX'(2);

  typedef enum logic [2:0] {IDLE, MSK, SEL, DAT, ERR} state_t;

  state_t             r_state;
  state_t             w_stateNxt;
  logic [W-1:0]       r_msk;
  logic [P_CH-1:0]    r_sel;
  logic [P_CH*W-1:0]  r_ctl;
  logic [P_CH*W-1:0]  r_shd;
  logic [P_CH-1:0]    r_pend;
  logic [P_CH-1:0]    r_upd;
  logic               r_err;

  logic               w_capMsk;
  logic               w_capSel;
  logic               w_wr;
  logic               w_err;
  logic [W-1:0]       w_wdat;
  logic [P_CH*W-1:0]  w_ctlNxt;
  logic [P_CH*W-1:0]  w_shdNxt;
  logic [P_CH-1:0]    w_pendNxt;
  logic [P_CH-1:0]    w_updNxt;
  logic               w_unused;

  assign w_wdat   = MSG_DAT_IN[W-1:0];
  assign w_unused = ^MSG_DAT_IN;

  // A first word restarts from any state; a last flag on the mask or select word is an early last.
  always_comb begin
    w_stateNxt = r_state;
    w_capMsk   = 1'b0;
    w_capSel   = 1'b0;
    w_wr       = 1'b0;
    w_err      = 1'b0;
    if (MSG_VLD_IN) begin
      if (MSG_FIRST_IN) begin
        if (MSG_IDX_IN == LP_IDX_MSK && !MSG_LAST_IN) begin
          w_capMsk   = 1'b1;
          w_stateNxt = MSK;
        end else begin
          w_err      = 1'b1;
          w_stateNxt = ERR;
        end
      end else begin
        case (r_state)
          MSK: begin
            if (MSG_IDX_IN == LP_IDX_SEL && !MSG_LAST_IN) begin
              w_capSel   = 1'b1;
              w_stateNxt = SEL;
            end else begin
              w_err      = 1'b1;
              w_stateNxt = ERR;
            end
          end
          SEL: begin
            if (MSG_IDX_IN == LP_IDX_DAT && MSG_LAST_IN) begin
              w_wr       = 1'b1;
              w_stateNxt = DAT;
            end else begin
              w_err      = 1'b1;
              w_stateNxt = ERR;
            end
          end
          ERR: w_stateNxt = ERR;
          default: begin
            w_err      = 1'b1;
            w_stateNxt = ERR;
          end
        endcase
      end
    end else if (r_state == DAT) begin
      w_stateNxt = IDLE;
    end
  end

  // Commit reads the old shadow, so a write in the SYNC_IN cycle stays pending for the next one.
  for (genvar c = 0; c < P_CH; c++) begin : g_ch
    logic [W-1:0] w_cur;
    logic [W-1:0] w_shd;
    logic [W-1:0] w_wrMsk;
    logic [W-1:0] w_nxt;
    logic         w_com;

    assign w_cur   = r_ctl[c*W +: W];
    assign w_shd   = r_shd[c*W +: W];
    assign w_wrMsk = (w_wr && r_sel[c]) ? r_msk : '0;
    assign w_com   = SYNC_IN && r_pend[c];

    assign w_nxt = (w_cur & LP_LVL_IMM & ~w_wrMsk)
                 | (w_wdat & w_wrMsk & (LP_LVL_IMM | LP_PLS_IMM))
                 | (w_com ? (w_shd & (LP_LVL_SYNC | LP_PLS_SYNC)) : (w_cur & LP_LVL_SYNC));

    assign w_ctlNxt[c*W +: W] = w_nxt;
    assign w_shdNxt[c*W +: W] = ((w_com ? (w_shd & ~LP_PLS_SYNC) : w_shd) & ~(w_wrMsk & P_SYNC_MSK))
                              | (w_wdat & w_wrMsk & P_SYNC_MSK);
    assign w_pendNxt[c] = (|(w_wrMsk & P_SYNC_MSK)) | (r_pend[c] & ~w_com);
    assign w_updNxt[c]  = |((w_nxt ^ w_cur) & ~P_PLS_MSK);
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state <= IDLE;
      r_msk   <= '0;
      r_sel   <= '0;
      r_ctl   <= {P_CH{P_RST_VAL}};
      r_shd   <= {P_CH{P_RST_VAL}};
      r_pend  <= '0;
      r_upd   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      if (w_capMsk) r_msk <= w_wdat;
      if (w_capSel) r_sel <= MSG_DAT_IN[P_CH-1:0];
      r_ctl   <= w_ctlNxt;
      r_shd   <= w_shdNxt;
      r_pend  <= w_pendNxt;
      r_upd   <= w_updNxt;
      r_err   <= w_err;
    end
  end

  assign CTL_OUT     = r_ctl;
  assign CTL_UPD_OUT = r_upd;
  assign ERR_OUT     = r_err;

endmodule

// File: tb/tb_prt_dptx_ctl_bank.sv
// Directed self-checking bench for prt_dptx_ctl_bank: 4 channels x 8 bits,
// bit 7 is a pulse bit and bit 6 is a frame-synchronised bit.
module tb_prt_dptx_ctl_bank;

  logic        RST_IN;
  logic        CLK_IN;
  logic [4:0]  MSG_IDX_IN;
  logic        MSG_FIRST_IN;
  logic        MSG_LAST_IN;
  logic [15:0] MSG_DAT_IN;
  logic        MSG_VLD_IN;
  logic        SYNC_IN;
  logic [31:0] CTL_OUT;
  logic [3:0]  CTL_UPD_OUT;
  logic        ERR_OUT;

  int passCnt  = 0;
  int totalCnt = 0;

  prt_dptx_ctl_bank #(
    .P_MSG_IDX(5), .P_MSG_DAT(16), .P_CH(4), .P_CTL_WIDTH(8),
    .P_PLS_MSK(8'h80), .P_SYNC_MSK(8'h40), .P_RST_VAL(8'h00)
  ) dut (
    .RST_IN(RST_IN), .CLK_IN(CLK_IN),
    .MSG_IDX_IN(MSG_IDX_IN), .MSG_FIRST_IN(MSG_FIRST_IN), .MSG_LAST_IN(MSG_LAST_IN),
    .MSG_DAT_IN(MSG_DAT_IN), .MSG_VLD_IN(MSG_VLD_IN), .SYNC_IN(SYNC_IN),
    .CTL_OUT(CTL_OUT), .CTL_UPD_OUT(CTL_UPD_OUT), .ERR_OUT(ERR_OUT)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  // Drives one word for one clock; returns 1 time unit after the edge that took it.
  task automatic word(input logic [4:0] idx, input logic first, input logic last,
                      input logic [15:0] dat, input logic sync);
    MSG_IDX_IN   = idx;
    MSG_FIRST_IN = first;
    MSG_LAST_IN  = last;
    MSG_DAT_IN   = dat;
    MSG_VLD_IN   = 1'b1;
    SYNC_IN      = sync;
    @(posedge CLK_IN); #1;
    MSG_VLD_IN   = 1'b0;
    MSG_FIRST_IN = 1'b0;
    MSG_LAST_IN  = 1'b0;
    SYNC_IN      = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK_IN); #1;
  endtask

  task automatic pulseSync();
    SYNC_IN = 1'b1;
    @(posedge CLK_IN); #1;
    SYNC_IN = 1'b0;
  endtask

  task automatic sendMsg(input logic [7:0] msk, input logic [3:0] sel, input logic [7:0] dat);
    word(5'd0, 1'b1, 1'b0, {8'h00, msk}, 1'b0);
    word(5'd1, 1'b0, 1'b0, {12'h000, sel}, 1'b0);
    word(5'd2, 1'b0, 1'b1, {8'hFF, dat}, 1'b0);
  endtask

  task automatic test_reset();
    RST_IN = 1'b1;
    MSG_IDX_IN = '0; MSG_FIRST_IN = 0; MSG_LAST_IN = 0; MSG_DAT_IN = '0;
    MSG_VLD_IN = 0; SYNC_IN = 0;
    repeat (2) @(posedge CLK_IN);
    #1;
    totalCnt++;
    if (CTL_OUT !== 32'h0) $display("[TB] FAIL reset_ctl got %h want %h", CTL_OUT, 32'h0);
    else passCnt++;
    totalCnt++;
    if (CTL_UPD_OUT !== 4'h0 || ERR_OUT !== 1'b0)
      $display("[TB] FAIL reset_upd_err got upd=%b err=%b want 0000/0", CTL_UPD_OUT, ERR_OUT);
    else passCnt++;
    RST_IN = 1'b0;
    idle();
  endtask

  task automatic test_masked_write();
    sendMsg(8'h0F, 4'h5, 8'hA5);
    totalCnt++;
    if (CTL_OUT !== 32'h00050005) $display("[TB] FAIL masked_ctl got %h want %h", CTL_OUT, 32'h00050005);
    else passCnt++;
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b0101) $display("[TB] FAIL masked_upd got %b want 0101", CTL_UPD_OUT);
    else passCnt++;
    idle();
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b0000 || CTL_OUT !== 32'h00050005)
      $display("[TB] FAIL masked_hold got upd=%b ctl=%h want 0000/00050005", CTL_UPD_OUT, CTL_OUT);
    else passCnt++;
    sendMsg(8'h0F, 4'h1, 8'h05);
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b0000) $display("[TB] FAIL same_value_upd got %b want 0000", CTL_UPD_OUT);
    else passCnt++;
    sendMsg(8'hFF, 4'h0, 8'hFF);
    totalCnt++;
    if (CTL_OUT !== 32'h00050005 || ERR_OUT !== 1'b0 || CTL_UPD_OUT !== 4'b0000)
      $display("[TB] FAIL empty_sel got ctl=%h err=%b upd=%b want 00050005/0/0000", CTL_OUT, ERR_OUT, CTL_UPD_OUT);
    else passCnt++;
    idle();
  endtask

  task automatic test_pulse();
    sendMsg(8'h80, 4'h1, 8'h80);
    totalCnt++;
    if (CTL_OUT !== 32'h00050085) $display("[TB] FAIL pulse_high got %h want %h", CTL_OUT, 32'h00050085);
    else passCnt++;
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b0000) $display("[TB] FAIL pulse_upd got %b want 0000", CTL_UPD_OUT);
    else passCnt++;
    idle();
    totalCnt++;
    if (CTL_OUT !== 32'h00050005) $display("[TB] FAIL pulse_clear got %h want %h", CTL_OUT, 32'h00050005);
    else passCnt++;
  endtask

  task automatic test_sync();
    sendMsg(8'h40, 4'h2, 8'h40);
    totalCnt++;
    if (CTL_OUT !== 32'h00050005 || CTL_UPD_OUT !== 4'b0000)
      $display("[TB] FAIL sync_staged got ctl=%h upd=%b want 00050005/0000", CTL_OUT, CTL_UPD_OUT);
    else passCnt++;
    idle();
    idle();
    totalCnt++;
    if (CTL_OUT !== 32'h00050005) $display("[TB] FAIL sync_wait got %h want %h", CTL_OUT, 32'h00050005);
    else passCnt++;
    pulseSync();
    totalCnt++;
    if (CTL_OUT !== 32'h00054005) $display("[TB] FAIL sync_commit got %h want %h", CTL_OUT, 32'h00054005);
    else passCnt++;
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b0010) $display("[TB] FAIL sync_upd got %b want 0010", CTL_UPD_OUT);
    else passCnt++;
    idle();
    pulseSync();
    totalCnt++;
    if (CTL_OUT !== 32'h00054005 || CTL_UPD_OUT !== 4'b0000)
      $display("[TB] FAIL sync_again got ctl=%h upd=%b want 00054005/0000", CTL_OUT, CTL_UPD_OUT);
    else passCnt++;
  endtask

  task automatic test_sync_simul();
    sendMsg(8'h40, 4'h8, 8'h40);
    word(5'd0, 1'b1, 1'b0, 16'h0040, 1'b0);
    word(5'd1, 1'b0, 1'b0, 16'h0008, 1'b0);
    word(5'd2, 1'b0, 1'b1, 16'h0000, 1'b1);
    totalCnt++;
    if (CTL_OUT !== 32'h40054005) $display("[TB] FAIL simul_old got %h want %h", CTL_OUT, 32'h40054005);
    else passCnt++;
    totalCnt++;
    if (CTL_UPD_OUT !== 4'b1000) $display("[TB] FAIL simul_upd got %b want 1000", CTL_UPD_OUT);
    else passCnt++;
    idle();
    pulseSync();
    totalCnt++;
    if (CTL_OUT !== 32'h00054005) $display("[TB] FAIL simul_new got %h want %h", CTL_OUT, 32'h00054005);
    else passCnt++;
    idle();
  endtask

  task automatic test_malformed();
    word(5'd0, 1'b1, 1'b0, 16'h00FF, 1'b0);
    word(5'd2, 1'b0, 1'b1, 16'h00FF, 1'b0);
    totalCnt++;
    if (ERR_OUT !== 1'b1) $display("[TB] FAIL err_skip_sel got %b want 1", ERR_OUT);
    else passCnt++;
    idle();
    totalCnt++;
    if (ERR_OUT !== 1'b0 || CTL_OUT !== 32'h00054005)
      $display("[TB] FAIL err_nochange got err=%b ctl=%h want 0/00054005", ERR_OUT, CTL_OUT);
    else passCnt++;
    word(5'd1, 1'b1, 1'b0, 16'h000F, 1'b0);
    totalCnt++;
    if (ERR_OUT !== 1'b1) $display("[TB] FAIL err_first_idx1 got %b want 1", ERR_OUT);
    else passCnt++;
    word(5'd2, 1'b0, 1'b1, 16'h00FF, 1'b0);
    totalCnt++;
    if (ERR_OUT !== 1'b0 || CTL_OUT !== 32'h00054005)
      $display("[TB] FAIL err_discard got err=%b ctl=%h want 0/00054005", ERR_OUT, CTL_OUT);
    else passCnt++;
    sendMsg(8'h0F, 4'h8, 8'h03);
    totalCnt++;
    if (CTL_OUT !== 32'h03054005 || CTL_UPD_OUT !== 4'b1000 || ERR_OUT !== 1'b0)
      $display("[TB] FAIL err_recover got ctl=%h upd=%b err=%b want 03054005/1000/0", CTL_OUT, CTL_UPD_OUT, ERR_OUT);
    else passCnt++;
    idle();
    word(5'd2, 1'b0, 1'b1, 16'h00FF, 1'b0);
    totalCnt++;
    if (ERR_OUT !== 1'b1) $display("[TB] FAIL err_no_first got %b want 1", ERR_OUT);
    else passCnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    sendMsg(8'h0F, 4'h1, 8'h0A);
    totalCnt++;
    if (CTL_OUT !== 32'h0305400A || CTL_UPD_OUT !== 4'b0001)
      $display("[TB] FAIL b2b_first got ctl=%h upd=%b want 0305400A/0001", CTL_OUT, CTL_UPD_OUT);
    else passCnt++;
    sendMsg(8'h0F, 4'h2, 8'h0B);
    totalCnt++;
    if (CTL_OUT !== 32'h03054B0A || CTL_UPD_OUT !== 4'b0010 || ERR_OUT !== 1'b0)
      $display("[TB] FAIL b2b_second got ctl=%h upd=%b err=%b want 03054B0A/0010/0", CTL_OUT, CTL_UPD_OUT, ERR_OUT);
    else passCnt++;
    idle();
  endtask

  task automatic test_reset_mid();
    sendMsg(8'h40, 4'h1, 8'h40);
    word(5'd0, 1'b1, 1'b0, 16'h000F, 1'b0);
    word(5'd1, 1'b0, 1'b0, 16'h000F, 1'b0);
    RST_IN = 1'b1;
    #1;
    totalCnt++;
    if (CTL_OUT !== 32'h0 || CTL_UPD_OUT !== 4'b0000)
      $display("[TB] FAIL rst_mid got ctl=%h upd=%b want 00000000/0000", CTL_OUT, CTL_UPD_OUT);
    else passCnt++;
    @(posedge CLK_IN); #1;
    RST_IN = 1'b0;
    idle();
    word(5'd2, 1'b0, 1'b1, 16'h00FF, 1'b0);
    totalCnt++;
    if (ERR_OUT !== 1'b1 || CTL_OUT !== 32'h0)
      $display("[TB] FAIL rst_data_err got err=%b ctl=%h want 1/00000000", ERR_OUT, CTL_OUT);
    else passCnt++;
    idle();
    pulseSync();
    totalCnt++;
    if (CTL_OUT !== 32'h0 || CTL_UPD_OUT !== 4'b0000)
      $display("[TB] FAIL rst_pend_clear got ctl=%h upd=%b want 00000000/0000", CTL_OUT, CTL_UPD_OUT);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_pulse();
    test_sync();
    test_sync_simul();
    test_malformed();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
